// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver, 8N1 default, oversampled on pulse_rx ticks
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        asynchronous active-low reset
//   pulse_rx   oversample tick, one clk wide, OVERSAMPLE ticks per bit time
//   rx         serial line, idle high, asynchronous to clk
//   rx_data    last good byte, held until the next good frame
//   rx_val     1-clk strobe, rx_data updated this cycle
//   frame_err  1-clk strobe, stop bit sampled 0 and the byte was discarded
//   busy       high while a frame or the post-error line-low wait is in progress
//
// Optional feature macro: UART_RX_MAJORITY_EN
//   defined   - each decision uses a 2-of-3 majority over the last three ticks
//   undefined - each decision uses the single rx_s value at the decision tick

module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pulse_rx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_val,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 val_q, val_d;
    logic                 err_q, err_d;

    logic rx_meta, rx_s;
    logic sample;

    // Two-flop synchroniser; resets to the idle-high line level so a reset
    // never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // Holds rx_s from the two previous ticks; the live rx_s at the decision
    // tick is the third vote, so the majority covers three consecutive ticks.
    logic [1:0] hist_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= 2'b11;
        end else if (pulse_rx) begin
            hist_q <= {hist_q[0], rx_s};
        end
    end

    assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
    assign sample = rx_s;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            val_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            val_q   <= val_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        val_d   = 1'b0;
        err_d   = 1'b0;

        if (pulse_rx) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        tick_d  = '0;
                        state_d = START;
                    end
                end
                START: begin
                    // Half a bit after the falling edge: still low means a real start.
                    if (tick_q == HALF_M1) begin
                        if (!sample) begin
                            tick_d  = '0;
                            bit_d   = '0;
                            state_d = DATA;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                DATA: begin
                    if (tick_q == FULL_M1) begin
                        shift_d[bit_q] = sample;
                        tick_d         = '0;
                        if (bit_q == LAST_BIT) begin
                            bit_d   = '0;
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                STOP: begin
                    // Leaving at mid stop bit leaves half a bit to catch the
                    // next start edge of a back-to-back frame.
                    if (tick_q == FULL_M1) begin
                        tick_d = '0;
                        if (sample) begin
                            data_d  = shift_q;
                            val_d   = 1'b1;
                            state_d = IDLE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = BREAK;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                BREAK: begin
                    // Wait for the line to return high so a held-low break
                    // is not mistaken for a stream of start bits.
                    if (rx_s) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign rx_data   = data_q;
    assign rx_val    = val_q;
    assign frame_err = err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard testbench for uart_rx

`timescale 1ns/1ps

module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       pulse_rx;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_val;
    logic       frame_err;
    logic       busy;

    uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .pulse_rx  (pulse_rx),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_val    (rx_val),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // One pulse_rx every 27 clk, driven on the falling edge.
    initial begin
        pulse_rx = 1'b0;
        forever begin
            repeat (26) @(negedge clk);
            pulse_rx = 1'b1;
            @(negedge clk);
            pulse_rx = 1'b0;
        end
    end

    typedef struct {
        bit         err;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] last_good;
    int         n_total = 0;
    int         n_pass  = 0;
    int         val_count = 0;
    int         err_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Present one value on rx for exactly one pulse_rx tick. Called right
    // after a tick, so the synchroniser has settled before the next one.
    task automatic tick(input logic v);
        rx = v;
        do @(posedge clk); while (!pulse_rx);
        @(negedge clk);
    endtask

    task automatic ticks(input logic v, input int n);
        for (int i = 0; i < n; i++) tick(v);
    endtask

    // Reference model: a frame is 16 ticks per bit, start + 8 data LSB-first
    // + stop. A one-tick glitch at the centre tick of a data bit flips that
    // bit unless the majority filter is built.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int glitch_bit);
        exp_t e;
        logic [7:0] d;
        logic v;
        d = b;
`ifndef UART_RX_MAJORITY_EN
        if (glitch_bit >= 0) d = b ^ (8'h01 << glitch_bit);
`endif
        e.err  = !stop_ok;
        e.data = d;
        exp_q.push_back(e);
        ticks(1'b0, 16);
        for (int i = 0; i < 8; i++) begin
            for (int t = 0; t < 16; t++) begin
                v = b[i];
                if (i == glitch_bit && t == 8) v = ~v;
                tick(v);
            end
        end
        ticks(stop_ok ? 1'b1 : 1'b0, 16);
    endtask

    // Monitor: pops the scoreboard on every strobe.
    initial begin
        exp_t e;
        bit   prev_strobe;
        prev_strobe = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && (rx_val || frame_err)) begin
                check("strobe_width", {31'd0, prev_strobe}, 32'd0);
                check("val_and_err_exclusive", {31'd0, rx_val & frame_err}, 32'd0);
                if (rx_val) val_count++;
                if (frame_err) err_count++;
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", {31'd0, rx_val}, {31'd0, frame_err});
                    check("unexpected_strobe_any", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    if (e.err) begin
                        check("frame_err_kind", {31'd0, frame_err}, 32'd1);
                        check("rx_data_held", {24'd0, rx_data}, {24'd0, last_good});
                    end else begin
                        check("rx_val_kind", {31'd0, rx_val}, 32'd1);
                        check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
                        last_good = e.data;
                    end
                end
            end
            prev_strobe = rst && (rx_val || frame_err);
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         v0;
        int         g;
        bit         ok;
        logic [7:0] b;

        last_good = 8'h00;
        rst = 1'b0;
        rx  = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check("reset_rx_data", {24'd0, rx_data}, 32'd0);
        check("reset_rx_val", {31'd0, rx_val}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        do @(posedge clk); while (!pulse_rx);
        @(negedge clk);
        ticks(1'b1, 4);

        // 1: single good frame
        v0 = val_count;
        send_frame(8'hA5, 1'b1, -1);
        ticks(1'b1, 8);
        check("t1_one_rx_val", val_count - v0, 1);
        check("t1_rx_data", {24'd0, rx_data}, 32'hA5);
        check("t1_busy_idle", {31'd0, busy}, 32'd0);

        // 2: back-to-back, no idle gap
        v0 = val_count;
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        ticks(1'b1, 8);
        check("t2_two_rx_val", val_count - v0, 2);
        check("t2_pending", exp_q.size(), 0);

        // 3: false start
        v0 = val_count + err_count;
        tick(1'b0);
        check("t3_busy_high", {31'd0, busy}, 32'd1);
        ticks(1'b0, 2);
        ticks(1'b1, 12);
        check("t3_busy_low", {31'd0, busy}, 32'd0);
        check("t3_no_strobe", val_count + err_count - v0, 0);

        // 4: bad stop bit, line held low, then recovery
        send_frame(8'h3C, 1'b0, -1);
        ticks(1'b0, 16);
        check("t4_busy_break", {31'd0, busy}, 32'd1);
        ticks(1'b0, 16);
        check("t4_rx_data_kept", {24'd0, rx_data}, {24'd0, last_good});
        ticks(1'b1, 4);
        check("t4_busy_after_break", {31'd0, busy}, 32'd0);
        send_frame(8'h55, 1'b1, -1);
        ticks(1'b1, 4);
        check("t4_pending", exp_q.size(), 0);

        // 5: reset during bit 4 of 0x81
        b = 8'h81;
        v0 = val_count + err_count;
        ticks(1'b0, 16);
        for (int i = 0; i < 4; i++) ticks(b[i], 16);
        ticks(b[4], 8);
        rst = 1'b0;
        #1;
        check("t5_rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("t5_rst_rx_val", {31'd0, rx_val}, 32'd0);
        check("t5_rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        last_good = 8'h00;
        ticks(1'b1, 20);
        check("t5_no_strobe", val_count + err_count - v0, 0);
        send_frame(8'h81, 1'b1, -1);
        ticks(1'b1, 4);
        check("t5_rx_data", {24'd0, rx_data}, 32'h81);

        // 6: glitch at mid bit 2, then a random glitch
        send_frame(8'hF0, 1'b1, 2);
        ticks(1'b1, 4);
`ifdef UART_RX_MAJORITY_EN
        check("t6_glitch_data", {24'd0, rx_data}, 32'hF0);
`else
        check("t6_glitch_data", {24'd0, rx_data}, 32'hF4);
`endif
        send_frame(8'($urandom), 1'b1, int'($urandom_range(0, 7)));
        ticks(1'b1, 4);

        // Randomised frames with short gaps and occasional bad stop bits
        for (int n = 0; n < 6; n++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(0, 3) != 0);
            send_frame(b, ok, -1);
            ticks(1'b1, ok ? int'($urandom_range(0, 3)) : int'($urandom_range(1, 3)));
        end
        ticks(1'b1, 10);
        check("final_pending", exp_q.size(), 0);
        check("final_busy", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
